// File: rtl/codi_pkg.sv
`timescale 1ns/1ps
// Shared types and the Hamming(8,4) SECDED encode function for the codec arbiter.
package codi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        SEND = 2'd2
    } arb_state_t;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] codeword_t;

    // nibble bit 0 = d1 .. bit 3 = d4; c[7] is global parity over c[6:0]
    function automatic codeword_t hamming84_enc(input nibble_t n);
        codeword_t c;
        c       = '0;
        c[2]    = n[0];
        c[4]    = n[1];
        c[5]    = n[2];
        c[6]    = n[3];
        c[0]    = n[0] ^ n[1] ^ n[3];
        c[1]    = n[0] ^ n[2] ^ n[3];
        c[3]    = n[1] ^ n[2] ^ n[3];
        c[7]    = ^c[6:0];
        return c;
    endfunction

endpackage

// File: rtl/module_codi.sv
`timescale 1ns/1ps
// Shared combinational Hamming(8,4) SECDED encoder.
module module_codi
    import codi_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] code
);

    // Pure function of the latched nibble
    always_comb begin
        code = hamming84_enc(nib);
    end

endmodule

// File: rtl/module_codi_arb.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one SECDED encoder between two nibble sources,
// with a registered valid/ready codeword output and per-source delivery counters.
module module_codi_arb
    import codi_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int FIRST_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_data,
    output logic             req1_ready,
    output logic             cod_valid,
    output logic [7:0]       cod_data,
    output logic             cod_src,
    input  logic             cod_ready,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic RR_INIT = (FIRST_PRIO != 0);

    arb_state_t state, state_nxt;
    logic       rr_ptr;
    logic [3:0] nib_q;
    logic       src_q;
    logic       gnt_any;
    logic       gnt_src;
    logic [7:0] enc_word;

    module_codi u_codi (
        .nib  (nib_q),
        .code (enc_word)
    );

    // Combinational grant: a lone requester always wins, contention goes to rr_ptr
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_src = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and source handshakes; readies only ever asserted in IDLE
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    req0_ready = ~gnt_src;
                    req1_ready = gnt_src;
                    state_nxt  = ENC;
                end
            end
            ENC:  state_nxt = SEND;
            SEND: begin
                if (cod_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Nibble capture, output register, round-robin pointer and delivery counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib_q     <= '0;
            src_q     <= 1'b0;
            cod_valid <= 1'b0;
            cod_data  <= '0;
            cod_src   <= 1'b0;
            rr_ptr    <= RR_INIT;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        nib_q <= gnt_src ? req1_data : req0_data;
                        src_q <= gnt_src;
                    end
                end
                ENC: begin
                    cod_data  <= enc_word;
                    cod_src   <= src_q;
                    cod_valid <= 1'b1;
                end
                SEND: begin
                    if (cod_ready) begin
                        cod_valid <= 1'b0;
                        rr_ptr    <= ~cod_src;
                        if (cod_src) begin
                            cnt1 <= cnt1 + CNT_W'(1);
                        end else begin
                            cnt0 <= cnt0 + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_module_codi_arb.sv
`timescale 1ns/1ps
// Scoreboard bench for module_codi_arb: stimulus pushes expected codewords,
// a monitor pops and compares on each output handshake.
module tb_module_codi_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_data, req1_data;
    logic       cod_valid, cod_src, cod_ready, busy;
    logic [7:0] cod_data;
    logic [7:0] cnt0, cnt1;

    logic       w_rst, w_req0_valid, w_req0_ready, w_req1_ready;
    logic [3:0] w_req0_data;
    logic       w_cod_valid, w_cod_src, w_busy;
    logic [7:0] w_cod_data;
    logic [1:0] w_cnt0, w_cnt1;

    always #5 clk = ~clk;

    module_codi_arb #(.CNT_W(8), .FIRST_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .cod_valid(cod_valid), .cod_data(cod_data), .cod_src(cod_src),
        .cod_ready(cod_ready), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    module_codi_arb #(.CNT_W(2), .FIRST_PRIO(0)) dut_w (
        .clk(clk), .rst(w_rst),
        .req0_valid(w_req0_valid), .req0_data(w_req0_data), .req0_ready(w_req0_ready),
        .req1_valid(1'b0), .req1_data(4'h0), .req1_ready(w_req1_ready),
        .cod_valid(w_cod_valid), .cod_data(w_cod_data), .cod_src(w_cod_src),
        .cod_ready(1'b1), .busy(w_busy), .cnt0(w_cnt0), .cnt1(w_cnt1)
    );

    typedef struct packed {
        logic       src;
        logic [7:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Hand-computed codewords for nibbles 0..F
    logic [7:0] enc_tab [16] = '{8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
                                 8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: ready exclusivity every cycle, scoreboard compare on each delivery
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [2:0] syn;
        if (!rst) begin
            check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (cod_valid && cod_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_word", 32'd1, {31'd0, cod_valid});
                    check("unexpected_word_present", 32'd0, 32'd1 - {31'd0, cod_valid} + 32'd1);
                end else begin
                    e   = sb_q.pop_front();
                    syn = {^(cod_data & 8'h78), ^(cod_data & 8'h66), ^(cod_data & 8'h55)};
                    check("cod_data", {24'd0, cod_data}, {24'd0, e.data});
                    check("cod_src", {31'd0, cod_src}, {31'd0, e.src});
                    check("syndrome", {29'd0, syn}, 32'd0);
                    check("parity", {31'd0, ^cod_data}, 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer one nibble, push its expected word, return one step after the accepting edge
    task automatic send(input logic src, input logic [3:0] n);
        bit got;
        got = 1'b0;
        if (src) begin
            req1_valid = 1'b1;
            req1_data  = n;
        end else begin
            req0_valid = 1'b1;
            req0_data  = n;
        end
        sb_q.push_back({src, enc_tab[n]});
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (src ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("handshake_timeout", {31'd0, got}, 32'd1);
        tick();
        if (src) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) break;
        end
        check("drain_queue_empty", sb_q.size(), 32'd0);
        check("drain_idle", {31'd0, busy}, 32'd0);
        tick();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] d0 [3];
        logic [3:0] d1 [3];
        logic [1:0] wrap_exp [5];
        int unsigned i0, i1, k;
        logic hs0, hs1, pred, got;

        d0       = '{4'h1, 4'h2, 4'h3};
        d1       = '{4'h4, 4'h5, 4'h6};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b1; w_rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
        cod_ready = 1'b0; w_req0_valid = 1'b0; w_req0_data = '0;
        #2;
        check("rst_cod_valid", {31'd0, cod_valid}, 32'd0);
        check("rst_cod_data", {24'd0, cod_data}, 32'd0);
        check("rst_cod_src", {31'd0, cod_src}, 32'd0);
        check("rst_cnt0", {24'd0, cnt0}, 32'd0);
        check("rst_cnt1", {24'd0, cnt1}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        rst = 1'b0; w_rst = 1'b0;

        // Single source, sink always ready
        cod_ready = 1'b1;
        send(1'b0, 4'h0);
        send(1'b0, 4'h1);
        send(1'b0, 4'hB);
        send(1'b0, 4'hF);
        drain();
        check("single_cnt0", {24'd0, cnt0}, 32'd4);
        check("single_cnt1", {24'd0, cnt1}, 32'd0);

        // Contention: both valid continuously, grants must alternate 0,1,0,1,...
        do_reset();
        i0 = 0; i1 = 0; k = 0;
        req0_valid = 1'b1; req0_data = d0[0];
        req1_valid = 1'b1; req1_data = d1[0];
        for (int t = 0; t < 100 && k < 6; t++) begin
            @(negedge clk);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            if (hs0 || hs1) begin
                pred = k[0];
                sb_q.push_back({pred, enc_tab[pred ? d1[k/2] : d0[k/2]]});
                k++;
                if (hs0) i0++;
                if (hs1) i1++;
            end
            tick();
            if (i0 < 3) req0_data = d0[i0]; else req0_valid = 1'b0;
            if (i1 < 3) req1_data = d1[i1]; else req1_valid = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("contention_words", k, 32'd6);
        drain();
        check("contention_cnt0", {24'd0, cnt0}, 32'd3);
        check("contention_cnt1", {24'd0, cnt1}, 32'd3);

        // Backpressure: word held in SEND while source 1 waits
        cod_ready = 1'b0;
        send(1'b0, 4'h6);
        req1_valid = 1'b1; req1_data = 4'hA;
        sb_q.push_back({1'b1, enc_tab[4'hA]});
        tick();
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, cod_valid}, 32'd1);
            check("bp_data", {24'd0, cod_data}, 32'h33);
            check("bp_src", {31'd0, cod_src}, 32'd0);
            check("bp_ready0", {31'd0, req0_ready}, 32'd0);
            check("bp_ready1", {31'd0, req1_ready}, 32'd0);
        end
        tick();
        cod_ready = 1'b1;
        tick();
        cod_ready = 1'b0;
        check("bp_cnt0_once", {24'd0, cnt0}, 32'd4);
        check("bp_cnt1_none", {24'd0, cnt1}, 32'd3);
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("bp_req1_grant", {31'd0, got}, 32'd1);
        tick();
        req1_valid = 1'b0;
        cod_ready = 1'b1;
        drain();
        check("bp_cnt0_final", {24'd0, cnt0}, 32'd4);
        check("bp_cnt1_final", {24'd0, cnt1}, 32'd4);

        // Exhaustive encode through source 1
        for (int n = 0; n < 16; n++) begin
            send(1'b1, 4'(n));
        end
        drain();
        check("exh_cnt1", {24'd0, cnt1}, 32'd20);

        // Reset while a word is sitting in SEND: dropped immediately, never counted
        cod_ready = 1'b0;
        send(1'b0, 4'h3);
        tick();
        check("pre_rst_valid", {31'd0, cod_valid}, 32'd1);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("async_rst_valid", {31'd0, cod_valid}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_cnt0", {24'd0, cnt0}, 32'd0);
        check("async_rst_cnt1", {24'd0, cnt1}, 32'd0);
        check("async_rst_data", {24'd0, cod_data}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        cod_ready = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        check("post_rst_cnt0", {24'd0, cnt0}, 32'd0);

        // Counter wrap on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            w_req0_valid = 1'b1;
            w_req0_data  = 4'(i + 2);
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (w_req0_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            check("wrap_grant", {31'd0, got}, 32'd1);
            tick();
            w_req0_valid = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (w_cod_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            check("wrap_valid", {31'd0, got}, 32'd1);
            check("wrap_data", {24'd0, w_cod_data}, {24'd0, enc_tab[i + 2]});
            check("wrap_src", {31'd0, w_cod_src}, 32'd0);
            tick();
            check("wrap_cnt0", {30'd0, w_cnt0}, {30'd0, wrap_exp[i]});
            check("wrap_cnt1", {30'd0, w_cnt1}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
